// File: rtl/mux_2d.sv
// rtl/mux_2d.sv - 2:1 word mux with combinational output and registered copy of data and select
// Optional select-switch statistics are enabled by defining MUX_2D_STATS_EN.
module mux_2d #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mux_ctl,
  input  logic [WIDTH-1:0]     din0,
  input  logic [WIDTH-1:0]     din1,
  input  logic                 reg_en,
  output logic [WIDTH-1:0]     mux_out,
  output logic [WIDTH-1:0]     mux_out_q,
  output logic                 sel_q,
  output logic [CNT_WIDTH-1:0] sw_count,
  output logic                 sw_sat
);

  logic             w_sel;
  logic [WIDTH-1:0] r_mux_out_q;
  logic             r_sel_q;

  // Only a clean 1 selects din1; X/Z falls back to din0.
  assign w_sel   = (mux_ctl === 1'b1);
  assign mux_out = w_sel ? din1 : din0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_out_q <= '0;
      r_sel_q     <= 1'b0;
    end else if (reg_en) begin
      r_mux_out_q <= mux_out;
      r_sel_q     <= w_sel;
    end
  end

  assign mux_out_q = r_mux_out_q;
  assign sel_q     = r_sel_q;

`ifdef MUX_2D_STATS_EN
  logic [CNT_WIDTH-1:0] r_sw_count;
  logic                 w_sat;

  assign w_sat = &r_sw_count;

  // Counts registered select changes; parks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_count <= '0;
    end else if (reg_en && (w_sel != r_sel_q) && !w_sat) begin
      r_sw_count <= r_sw_count + 1'b1;
    end
  end

  assign sw_count = r_sw_count;
  assign sw_sat   = w_sat;
`else
  assign sw_count = '0;
  assign sw_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_2d.sv
// tb/tb_mux_2d.sv - self-checking bench for mux_2d (both MUX_2D_STATS_EN builds)
module tb_mux_2d;

`ifdef MUX_2D_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mux_ctl;
  logic        reg_en;
  logic [31:0] din0, din1;
  logic [4:0]  din0_5, din1_5;

  logic [31:0] mux_out, mux_out_q;
  logic        sel_q, sw_sat;
  logic [15:0] sw_count;
  logic [4:0]  mux_out5, mux_out_q5;
  logic        sel_q5, sw_sat5;
  logic [15:0] sw_count5;
  logic [31:0] mux_out2, mux_out_q2;
  logic        sel_q2, sw_sat2;
  logic [1:0]  sw_count2;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] m_q;
  logic        m_sel;
  int          m_changes;

  always #5 clk = ~clk;

  mux_2d #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .mux_ctl(mux_ctl), .din0(din0), .din1(din1), .reg_en(reg_en),
    .mux_out(mux_out), .mux_out_q(mux_out_q), .sel_q(sel_q), .sw_count(sw_count), .sw_sat(sw_sat)
  );

  mux_2d #(.WIDTH(5), .CNT_WIDTH(16)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .mux_ctl(mux_ctl), .din0(din0_5), .din1(din1_5), .reg_en(reg_en),
    .mux_out(mux_out5), .mux_out_q(mux_out_q5), .sel_q(sel_q5), .sw_count(sw_count5), .sw_sat(sw_sat5)
  );

  mux_2d #(.WIDTH(32), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mux_ctl(mux_ctl), .din0(din0), .din1(din1), .reg_en(reg_en),
    .mux_out(mux_out2), .mux_out_q(mux_out_q2), .sel_q(sel_q2), .sw_count(sw_count2), .sw_sat(sw_sat2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_mux(input logic ctl, input logic [31:0] a, input logic [31:0] b);
    return (ctl === 1'b1) ? b : a;
  endfunction

  function automatic int sat_count(input int changes, input int cnt_w);
    int lim;
    lim = (1 << cnt_w) - 1;
    if (!STATS) return 0;
    return (changes > lim) ? lim : changes;
  endfunction

  // Advance one clock edge, updating the model from the inputs present at that edge.
  task automatic step();
    if (reg_en && rst_n) begin
      if ((mux_ctl === 1'b1) != m_sel) m_changes++;
      m_q   = ref_mux(mux_ctl, din0, din1);
      m_sel = (mux_ctl === 1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_q"},      mux_out_q, m_q);
    check({tag, "_sel"},    sel_q, m_sel);
    check({tag, "_cnt"},    sw_count, sat_count(m_changes, 16));
    check({tag, "_sat"},    sw_sat, (sat_count(m_changes, 16) == 65535));
    check({tag, "_cnt2"},   sw_count2, sat_count(m_changes, 2));
    check({tag, "_sat2"},   sw_sat2, (sat_count(m_changes, 2) == 3));
    check({tag, "_q2"},     mux_out_q2, m_q);
  endtask

  task automatic model_reset();
    m_q = '0; m_sel = 1'b0; m_changes = 0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; mux_ctl = 1'b0; reg_en = 1'b0;
    din0 = 32'd123456; din1 = 32'd555555; din0_5 = 5'd10; din1_5 = 5'd20;
    #1;
    check("rst_q",   mux_out_q, 0);
    check("rst_sel", sel_q, 0);
    check("rst_cnt", sw_count, 0);
    check("rst_sat", sw_sat, 0);
    check("comb_ctl0_in_reset", mux_out, 32'd123456);
    @(negedge clk);
    rst_n = 1'b1;

    mux_ctl = 1'b1; #1;
    check("comb_ctl1", mux_out, 32'd555555);
    check("w5_ctl1", mux_out5, 5'd20);
    mux_ctl = 1'b0; #1;
    check("w5_ctl0", mux_out5, 5'd10);
    mux_ctl = 1'bx; din0 = 32'hA5A5A5A5; #1;
    check("ctl_x", mux_out, 32'hA5A5A5A5);

    // load, then hold with reg_en low
    mux_ctl = 1'b1; din1 = 32'd555555; reg_en = 1'b1;
    step();
    check("load_q", mux_out_q, 32'd555555);
    check("load_sel", sel_q, 1);
    check_regs("load");
    reg_en = 1'b0; din1 = 32'd7;
    step();
    check("hold_q", mux_out_q, 32'd555555);
    check("hold_comb", mux_out, 32'd7);
    check_regs("hold");

    // five toggles on loading edges from a fresh reset
    #2 rst_n = 1'b0; #1;
    model_reset();
    check("async_rst_q", mux_out_q, 0);
    check("async_rst_sel", sel_q, 0);
    check("async_rst_comb", mux_out, 32'd7);
    @(negedge clk);
    rst_n = 1'b1; reg_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mux_ctl = ~i[0];
      step();
    end
    check("tog5_cnt2", sw_count2, STATS ? 2'd3 : 2'd0);
    check("tog5_sat2", sw_sat2, STATS);
    check_regs("tog5");

    // randomized run against the model
    for (int i = 0; i < 200; i++) begin
      din0    = $urandom;
      din1    = $urandom;
      din0_5  = 5'($urandom);
      din1_5  = 5'($urandom);
      mux_ctl = 1'($urandom);
      reg_en  = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_comb", mux_out, ref_mux(mux_ctl, din0, din1));
      check("rnd_comb5", mux_out5, mux_ctl ? din1_5 : din0_5);
      step();
      check_regs("rnd");
      if (i == 120) begin
        #2 rst_n = 1'b0; #1;
        model_reset();
        check("rnd_rst_q", mux_out_q, 0);
        check("rnd_rst_cnt", sw_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
